result_sequencer: RTL and testbench
===================================

RESULT_SEQUENCER -- requirements
Module: result_sequencer

Interface
REQ-001 Parameters: none; node count fixed at 16, data width fixed at 8 bits signed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 capture  input  1  one-cycle pulse; latch result0..result15 and n_nodes.
REQ-005 n_nodes  input  5  number of valid nodes to drain, nominal 1..16.
REQ-006 result0..result15  input  8 each, signed  per-node outputs of the MAC/activation array.
REQ-007 xnext  output  8 signed  serialized node value, feeds next-layer xin.
REQ-008 xnext_valid  output  1  xnext holds a valid beat.
REQ-009 xnext_ready  input  1  consumer accepts beat when high with xnext_valid.
REQ-010 last  output  1  current beat is the final node.
REQ-011 busy  output  1  high in DRAIN and DONE states.
REQ-012 done  output  1  one-cycle pulse after final beat is accepted.
REQ-013 argmax  output  4  index of the largest accepted value (ARGMAX_EN only).
REQ-014 max_val  output  8 signed  largest accepted value (ARGMAX_EN only).

Function
REQ-015 FSM states IDLE, DRAIN, DONE; reset state IDLE.
REQ-016 IDLE: capture=1 latches all 16 results into an internal buffer, sets idx=0, sets count=clamp(n_nodes), moves to DRAIN.
REQ-017 Clamp: n_nodes>16 -> 16; n_nodes=0 -> IDLE->DONE directly, zero beats, done pulses.
REQ-018 First beat: xnext_valid rises the cycle after capture (latency 1); xnext=buffer[0].
REQ-019 DRAIN: xnext=buffer[idx], xnext_valid=1; beat accepted when xnext_valid & xnext_ready.
REQ-020 While xnext_ready=0, xnext, last and idx hold stable; no beat dropped or duplicated.
REQ-021 On accepted beat with idx<count-1: idx increments, next value presented the following cycle; back-to-back beats at one per cycle when ready stays high.
REQ-022 last=1 exactly when idx==count-1 in DRAIN.
REQ-023 Accepted beat with last=1 -> DONE; DONE asserts done=1 for one cycle, xnext_valid=0, then returns to IDLE.
REQ-024 capture while busy is ignored; buffer and count are unchanged.
REQ-025 capture in the same cycle as return to IDLE (i.e. during DONE) is ignored; capture accepted only in IDLE.
REQ-026 xnext driven 0 whenever xnext_valid=0.
REQ-027 Signed values pass unmodified; no saturation or rescaling in this block.

Reset
REQ-028 reset=0 at a clock edge forces IDLE, idx=0, count=0, buffer cleared; xnext=0, xnext_valid=0, last=0, busy=0, done=0, argmax=0, max_val=0.
REQ-029 Reset mid-DRAIN aborts the drain; no done pulse; next capture after release starts fresh.

Configuration
REQ-030 Macro RESULT_SEQUENCER_ARGMAX_EN.
REQ-031 Defined: running max tracked over accepted beats; first beat initializes max; strictly greater replaces, so ties keep the lowest index; argmax/max_val update the cycle after each beat, are final when done pulses, and hold until next accepted capture, which clears them to 0.
REQ-032 Undefined: argmax and max_val ports remain present, tied to 0; no compare logic.

Verification
REQ-033 results 0..15 = 1..16, n_nodes=16, ready held 1 -> 16 consecutive beats 1..16, last on beat 16, done one cycle later.
REQ-034 n_nodes=4, ready toggles 1,0,0,1,... -> exactly 4 beats, values stable while ready=0, last only on the 4th.
REQ-035 n_nodes=0 -> no xnext_valid, done pulses; n_nodes=20 -> 16 beats.
REQ-036 reset=0 after 3rd beat -> all outputs 0 next cycle, no done; new capture drains from index 0.
REQ-037 ARGMAX_EN, results {-5,7,7,-128,...,0}, n_nodes=16 -> argmax=1, max_val=7 at done; capture while busy ignored.

Source files
------------

// File: rtl/result_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : result_sequencer
//  Description : Captures the 16 per-node results of a layer and drains the
//                first n_nodes of them as a valid/ready stream, one value per
//                accepted beat, for the next layer's input.
//                Optional feature macro: RESULT_SEQUENCER_ARGMAX_EN
//                (tracks the largest accepted value and its index).
//  Ports       : clk          - clock, all state changes on rising edge
//                reset        - synchronous, active-low
//                capture      - pulse; latch result0..15 and n_nodes (IDLE only)
//                n_nodes      - nodes to drain (0 -> no beats, >16 -> 16)
//                result0..15  - signed 8-bit node results
//                xnext        - serialized value (0 when not valid)
//                xnext_valid  - xnext holds a beat
//                xnext_ready  - consumer accepts beat
//                last         - current beat is the final node
//                busy         - drain or done phase in progress
//                done         - one-cycle pulse after final beat accepted
//                argmax       - index of largest accepted value
//                max_val      - largest accepted value
//  Revision    : 1.0 - initial release
// ============================================================================
module result_sequencer (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic [4:0]        n_nodes,
  input  logic signed [7:0] result0,
  input  logic signed [7:0] result1,
  input  logic signed [7:0] result2,
  input  logic signed [7:0] result3,
  input  logic signed [7:0] result4,
  input  logic signed [7:0] result5,
  input  logic signed [7:0] result6,
  input  logic signed [7:0] result7,
  input  logic signed [7:0] result8,
  input  logic signed [7:0] result9,
  input  logic signed [7:0] result10,
  input  logic signed [7:0] result11,
  input  logic signed [7:0] result12,
  input  logic signed [7:0] result13,
  input  logic signed [7:0] result14,
  input  logic signed [7:0] result15,
  output logic signed [7:0] xnext,
  output logic              xnext_valid,
  input  logic              xnext_ready,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic [3:0]        argmax,
  output logic signed [7:0] max_val
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic signed [7:0] buf_q [16];
  logic signed [7:0] buf_d [16];
  logic [3:0]        idx_q, idx_d;
  logic [4:0]        count_q, count_d;
  logic signed [7:0] results_in [16];
  logic              accept;
  logic              at_last;
  logic              capture_ok;

  assign results_in = '{result0,  result1,  result2,  result3,
                        result4,  result5,  result6,  result7,
                        result8,  result9,  result10, result11,
                        result12, result13, result14, result15};

  assign capture_ok = (state_q == S_IDLE) && capture;
  assign accept     = (state_q == S_DRAIN) && xnext_ready;
  // count_q is at least 1 whenever the FSM is in DRAIN
  assign at_last    = (state_q == S_DRAIN) && ({1'b0, idx_q} == (count_q - 5'd1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      buf_q   <= '{default: '0};
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          buf_d   = results_in;
          idx_d   = '0;
          count_d = (n_nodes > 5'd16) ? 5'd16 : n_nodes;
          state_d = (n_nodes == 5'd0) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (accept) begin
          if (at_last) state_d = S_DONE;
          else         idx_d   = idx_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    xnext_valid = (state_q == S_DRAIN);
    xnext       = xnext_valid ? buf_q[idx_q] : 8'sd0;
    last        = at_last;
    busy        = (state_q == S_DRAIN) || (state_q == S_DONE);
    done        = (state_q == S_DONE);
  end

`ifdef RESULT_SEQUENCER_ARGMAX_EN
  logic [3:0]        argmax_q, argmax_d;
  logic signed [7:0] max_q, max_d;

  // First beat seeds the max; only a strictly greater value replaces it,
  // so ties keep the lowest index.
  always_comb begin
    argmax_d = argmax_q;
    max_d    = max_q;
    if (capture_ok) begin
      argmax_d = '0;
      max_d    = '0;
    end else if (accept && ((idx_q == 4'd0) || (buf_q[idx_q] > max_q))) begin
      argmax_d = idx_q;
      max_d    = buf_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      argmax_q <= '0;
      max_q    <= '0;
    end else begin
      argmax_q <= argmax_d;
      max_q    <= max_d;
    end
  end

  assign argmax  = argmax_q;
  assign max_val = max_q;
`else
  logic unused_capture_ok;
  assign unused_capture_ok = capture_ok;
  assign argmax  = '0;
  assign max_val = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_result_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_sequencer
//  Description : Randomized and directed stimulus for result_sequencer with a
//                queue-based behavioural reference model and per-cycle compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_sequencer;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              capture = 1'b0;
  logic [4:0]        n_nodes = '0;
  logic signed [7:0] res [16];
  logic signed [7:0] xnext;
  logic              xnext_valid;
  logic              xnext_ready = 1'b0;
  logic              last;
  logic              busy;
  logic              done;
  logic [3:0]        argmax;
  logic signed [7:0] max_val;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  result_sequencer dut (
    .clk(clk), .reset(reset), .capture(capture), .n_nodes(n_nodes),
    .result0(res[0]),   .result1(res[1]),   .result2(res[2]),   .result3(res[3]),
    .result4(res[4]),   .result5(res[5]),   .result6(res[6]),   .result7(res[7]),
    .result8(res[8]),   .result9(res[9]),   .result10(res[10]), .result11(res[11]),
    .result12(res[12]), .result13(res[13]), .result14(res[14]), .result15(res[15]),
    .xnext(xnext), .xnext_valid(xnext_valid), .xnext_ready(xnext_ready),
    .last(last), .busy(busy), .done(done), .argmax(argmax), .max_val(max_val)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending beats are a queue of (value, node index); a done pulse is owed
  // once the queue empties after a capture.
  int  q_val [$];
  int  q_idx [$];
  bit  done_due = 1'b0;
  int  m_max = 0;
  int  m_arg = 0;

  always @(posedge clk) begin
    int v, i, n;
    if (!reset) begin
      q_val.delete(); q_idx.delete();
      done_due = 1'b0; m_max = 0; m_arg = 0;
    end else if (q_val.size() > 0) begin
      if (xnext_ready) begin
        v = q_val.pop_front();
        i = q_idx.pop_front();
        if (i == 0 || v > m_max) begin m_max = v; m_arg = i; end
        if (q_val.size() == 0) done_due = 1'b1;
      end
    end else if (done_due) begin
      done_due = 1'b0;
    end else if (capture) begin
      n = (n_nodes > 16) ? 16 : int'(n_nodes);
      m_max = 0; m_arg = 0;
      for (int k = 0; k < n; k++) begin q_val.push_back(int'(res[k])); q_idx.push_back(k); end
      if (n == 0) done_due = 1'b1;
    end
  end

  // ---------------- compare / monitor ----------------
  int cyc = 0;
  int beats_total = 0;
  int done_total = 0;
  int valid_total = 0;
  int last_beat_cyc = 0;
  int last_beat_val = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    bit ev;
    int ex;
    cyc++;
    ev = (q_val.size() > 0);
    ex = ev ? q_val[0] : 0;
    chk("xnext_valid", int'(xnext_valid), int'(ev));
    chk("xnext", int'(xnext), ex);
    chk("last", int'(last), int'(ev && q_val.size() == 1));
    chk("busy", int'(busy), int'(ev || done_due));
    chk("done", int'(done), int'(done_due && !ev));
`ifdef RESULT_SEQUENCER_ARGMAX_EN
    chk("argmax", int'(argmax), m_arg);
    chk("max_val", int'(max_val), m_max);
`else
    chk("argmax", int'(argmax), 0);
    chk("max_val", int'(max_val), 0);
`endif
    if (xnext_valid) valid_total++;
    if (xnext_valid && xnext_ready) begin
      beats_total++;
      if (last) begin last_beat_cyc = cyc; last_beat_val = int'(xnext); end
    end
    if (done) begin done_total++; done_cyc = cyc; end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_capture(input int n);
    n_nodes = 5'(n);
    capture = 1'b1;
    step();
    capture = 1'b0;
  endtask

  // Runs until a done pulse is seen; pattern mode toggles ready 1,0,0,1,...
  task automatic run_until_done(input string name, input bit pattern);
    int d0, c;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    d0 = done_total;
    c = 0;
    while (done_total == d0 && c < 200) begin
      if (pattern) xnext_ready = pat[c % 4];
      step();
      c++;
    end
    chk(name, done_total - d0, 1);
    xnext_ready = 1'b1;
  endtask

  initial begin
    int b0, d0, v0;
    for (int k = 0; k < 16; k++) res[k] = '0;
    repeat (3) step();
    // reset state pinned to literals
    chk("reset_valid", int'(xnext_valid), 0);
    chk("reset_busy", int'(busy), 0);
    reset = 1'b1;
    step();

    // Sequential 1..16, ready held high
    for (int k = 0; k < 16; k++) res[k] = 8'(k + 1);
    xnext_ready = 1'b1;
    b0 = beats_total;
    do_capture(16);
    @(negedge clk);
    chk("first_beat_value", int'(xnext), 1);
    chk("first_beat_valid", int'(xnext_valid), 1);
    chk("model_depth", q_val.size(), 16);
    run_until_done("seq16_done", 1'b0);
    chk("seq16_beats", beats_total - b0, 16);
    chk("seq16_last_value", last_beat_val, 16);
    chk("seq16_done_latency", done_cyc - last_beat_cyc, 1);
    step();

    // n_nodes=4 with ready toggling
    b0 = beats_total;
    do_capture(4);
    run_until_done("n4_done", 1'b1);
    chk("n4_beats", beats_total - b0, 4);
    chk("n4_last_value", last_beat_val, 4);
    step();

    // n_nodes=0: no beats, done pulses
    v0 = valid_total;
    do_capture(0);
    run_until_done("n0_done", 1'b0);
    chk("n0_no_valid", valid_total - v0, 0);
    step();

    // n_nodes=20 clamps to 16
    b0 = beats_total;
    do_capture(20);
    run_until_done("n20_done", 1'b0);
    chk("n20_beats", beats_total - b0, 16);
    step();

    // Reset after the third beat
    b0 = beats_total;
    d0 = done_total;
    do_capture(16);
    while (beats_total - b0 < 3) @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_valid", int'(xnext_valid), 0);
    chk("abort_busy", int'(busy), 0);
    repeat (3) step();
    chk("abort_no_done", done_total - d0, 0);
    for (int k = 0; k < 16; k++) res[k] = 8'(100 - k);
    do_capture(5);
    @(negedge clk);
    chk("restart_first_value", int'(xnext), 100);
    run_until_done("restart_done", 1'b0);
    step();

    // Argmax pattern with a capture attempt while busy
    for (int k = 0; k < 16; k++) res[k] = '0;
    res[0] = -8'sd5; res[1] = 8'sd7; res[2] = 8'sd7; res[3] = -8'sd128;
    do_capture(16);
    step();
    for (int k = 0; k < 16; k++) res[k] = 8'sd99;
    capture = 1'b1;
    step();
    capture = 1'b0;
    run_until_done("argmax_done", 1'b0);
`ifdef RESULT_SEQUENCER_ARGMAX_EN
    chk("argmax_at_done", int'(argmax), 1);
    chk("max_val_at_done", int'(max_val), 7);
`else
    chk("argmax_at_done", int'(argmax), 0);
    chk("max_val_at_done", int'(max_val), 0);
`endif
    step();

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 16; k++) res[k] = 8'($urandom);
      n_nodes     = 5'($urandom_range(0, 20));
      capture     = ($urandom_range(0, 5) == 0);
      xnext_ready = ($urandom_range(0, 2) != 0);
      reset       = ($urandom_range(0, 99) != 0);
      step();
    end
    reset = 1'b1;
    capture = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
